// File: rtl/microwave_ctrl.sv
// Microwave sequencing controller: synchronizes panel/door inputs, detects button
// presses and runs the IDLE/COOK/PAUSE/DONE machine with registered Moore outputs.
module microwave_ctrl #(
  parameter int unsigned BEEP_CYCLES = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       magnetron_on,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       beep,
  output logic       lamp_on,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int unsigned CW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [CW-1:0] BEEP_LOAD = CW'(BEEP_CYCLES - 1);

  // Bit order in the sync pipeline: {door_closed, clearn, stopn, startn}
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] synced;
  logic [2:0] prev_q;
  logic       start_press, stop_press, clear_press, door_ok;

  state_t        state_q, state_next;
  logic [CW-1:0] cnt_q, cnt_next;
  logic          clr_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= {door_closed, clearn, stopn, startn};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= synced[2:0];
    end
  end

  assign synced      = sync_q[SYNC_STAGES-1];
  assign start_press = prev_q[0] & ~synced[0];
  assign stop_press  = prev_q[1] & ~synced[1];
  assign clear_press = prev_q[2] & ~synced[2];
  assign door_ok     = synced[3];

  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    clr_next   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_press) begin
          clr_next = 1'b1;
        end else if (start_press && door_ok && !timer_done) begin
          state_next = COOK;
        end
      end
      COOK: begin
        if (clear_press) begin
          state_next = IDLE;
          clr_next   = 1'b1;
        end else if (timer_done) begin
          state_next = DONE;
          cnt_next   = BEEP_LOAD;
        end else if (!door_ok || stop_press) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_press || stop_press) begin
          state_next = IDLE;
          clr_next   = 1'b1;
        end else if (start_press && door_ok && !timer_done) begin
          state_next = COOK;
        end
      end
      DONE: begin
        if (start_press || stop_press || clear_press || !door_ok) begin
          state_next = IDLE;
        end else if (cnt_q == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_q - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      magnetron_on <= 1'b0;
      timer_en     <= 1'b0;
      timer_clear  <= 1'b0;
      beep         <= 1'b0;
      lamp_on      <= 1'b0;
    end else begin
      state_q      <= state_next;
      cnt_q        <= cnt_next;
      magnetron_on <= (state_next == COOK);
      timer_en     <= (state_next == COOK);
      timer_clear  <= clr_next;
      beep         <= (state_next == DONE);
      lamp_on      <= (state_next == COOK) || !door_ok;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a history-based reference model.
module tb_microwave_ctrl;

  localparam int BEEP = 4;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic       timer_done = 1'b0;
  logic       magnetron_on, timer_en, timer_clear, beep, lamp_on;
  logic [1:0] state;

  always #5 clk = ~clk;

  microwave_ctrl #(.BEEP_CYCLES(BEEP), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done),
    .magnetron_on(magnetron_on), .timer_en(timer_en), .timer_clear(timer_clear),
    .beep(beep), .lamp_on(lamp_on), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: raw input samples are kept in a queue; the machine reacts to
  // the sample taken SYNC edges earlier, and a press is a 1->0 step between samples.
  logic [3:0] hist [$];
  int   m_state;
  int   m_beeps;
  logic m_tclr, m_lamp, m_door;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC + 1; i++) hist.push_back(4'hF);
    m_state = 0; m_beeps = 0; m_tclr = 1'b0; m_lamp = 1'b0; m_door = 1'b1;
  endtask

  task automatic model_edge();
    logic [3:0] prv, cur;
    logic st, sp, cl;
    hist.push_back({door_closed, clearn, stopn, startn});
    prv = hist[0];
    cur = hist[1];
    void'(hist.pop_front());
    st = prv[0] & ~cur[0];
    sp = prv[1] & ~cur[1];
    cl = prv[2] & ~cur[2];
    m_door = cur[3];
    m_tclr = 1'b0;
    case (m_state)
      0: if (cl) m_tclr = 1'b1;
         else if (st && m_door && !timer_done) m_state = 1;
      1: if (cl) begin m_state = 0; m_tclr = 1'b1; end
         else if (timer_done) begin m_state = 3; m_beeps = 1; end
         else if (!m_door || sp) m_state = 2;
      2: if (cl || sp) begin m_state = 0; m_tclr = 1'b1; end
         else if (st && m_door && !timer_done) m_state = 1;
      default: if (st || sp || cl || !m_door || m_beeps == BEEP) m_state = 0;
               else m_beeps++;
    endcase
    m_lamp = (m_state == 1) || !m_door;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", state, m_state);
    check("magnetron_on", magnetron_on, m_state == 1);
    check("timer_en", timer_en, m_state == 1);
    check("timer_clear", timer_clear, m_tclr);
    check("beep", beep, m_state == 3);
    check("lamp_on", lamp_on, m_lamp);
    check("safety_mag_door", magnetron_on & ~m_door, 0);
    check("safety_mag_state", magnetron_on & (state != 2'b01), 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_start();
    startn = 1'b0; steps(3); startn = 1'b1; steps(2);
  endtask

  task automatic press_stop();
    stopn = 1'b0; steps(3); stopn = 1'b1; steps(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_outs"}, {magnetron_on, timer_en, timer_clear, beep, lamp_on}, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  int cnt;

  initial begin
    model_reset();
    #1 check_all_zero("reset");
    #11 rstn = 1'b1;
    steps(2);

    // Start from IDLE; holding the button must not create extra events
    startn = 1'b0; steps(3);
    check("start_cook", state, 1);
    check("start_lamp", lamp_on, 1);
    steps(3);
    startn = 1'b1; steps(3);
    check("hold_still_cook", state, 1);

    // Door open pauses; closing alone does not resume
    door_closed = 1'b0; steps(3);
    check("door_pause", state, 2);
    check("door_lamp", lamp_on, 1);
    door_closed = 1'b1; steps(4);
    check("door_stays_pause", state, 2);
    press_start();
    check("resume_cook", state, 1);

    // Uninterrupted end-of-cycle beep
    timer_done = 1'b1; step();
    timer_done = 1'b0;
    cnt = beep ? 1 : 0;
    for (int i = 0; i < 8; i++) begin step(); if (beep) cnt++; end
    check("beep_len", cnt, BEEP);
    check("beep_idle", state, 0);

    // Stop pauses, second stop clears with a single pulse
    press_start(); check("cook2", state, 1);
    press_stop();  check("stop_pause", state, 2);
    cnt = 0;
    stopn = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); if (timer_clear) cnt++; end
    stopn = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (timer_clear) cnt++; end
    check("stop_clear_pulses", cnt, 1);
    check("stop_idle", state, 0);

    // Start refused while the timer reads done
    timer_done = 1'b1; press_start();
    check("start_td_idle", state, 0);
    timer_done = 1'b0;

    // Clear outranks timer_done in the same cycle
    press_start(); check("cook3", state, 1);
    clearn = 1'b0; steps(2);
    timer_done = 1'b1; step();
    check("clear_vs_done", state, 0);
    check("clear_vs_done_tclr", timer_clear, 1);
    timer_done = 1'b0; clearn = 1'b1; steps(3);

    // Start+stop together in PAUSE go to IDLE
    press_start(); press_stop(); check("pause2", state, 2);
    startn = 1'b0; stopn = 1'b0; steps(3);
    check("pause_start_stop", state, 0);
    startn = 1'b1; stopn = 1'b1; steps(3);

    // Asynchronous reset mid-COOK and mid-DONE
    press_start(); check("cook4", state, 1);
    async_reset("rst_cook");
    step(); check("rst_cook_idle", state, 0);
    press_start();
    timer_done = 1'b1; step(); timer_done = 1'b0; step();
    check("done_before_rst", state, 3);
    async_reset("rst_done");
    steps(3);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      startn     = ($urandom_range(0, 7) != 0);
      stopn      = ($urandom_range(0, 15) != 0);
      clearn     = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 19) == 0) door_closed = ~door_closed;
      timer_done = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Clocked sequencing controller for the microwave: turns the front-panel buttons (startn, stopn, clearn), the door sensor and the countdown timer's done flag into magnetron, timer and beeper commands.
- Replaces the purely combinational set/reset control logic with an explicit state machine with pause/resume and an end-of-cycle beep.
- Sits between the panel/door inputs and the countdown timer plus magnetron driver.

Parameters:
- BEEP_CYCLES, 8, number of clock cycles beep stays high in DONE (≥1).
- SYNC_STAGES, 2, synchronizer depth for asynchronous panel/door inputs (≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- startn  input  1  start button, active-low, asynchronous.
- stopn  input  1  stop/pause button, active-low, asynchronous.
- clearn  input  1  clear/cancel button, active-low, asynchronous.
- door_closed  input  1  1 = door closed, asynchronous.
- timer_done  input  1  countdown reached zero, level, synchronous to clk.
- magnetron_on  output  1  magnetron enable.
- timer_en  output  1  countdown enable.
- timer_clear  output  1  one-cycle pulse: zero the countdown.
- beep  output  1  end-of-cycle beeper.
- lamp_on  output  1  cavity lamp.
- state  output  2  current state, for debug/display.

Behaviour:
- Reset: async on rstn low.
  - state=IDLE(00); all outputs 0; beep counter 0.
  - Synchronizer and edge-detect registers set to released levels: buttons 1, door 1.
- Input conditioning:
  - startn, stopn, clearn and door_closed each pass through SYNC_STAGES flops.
  - A press is a synchronized 1→0 transition. It is valid for exactly one cycle.
  - A held button produces one press only.
  - timer_done is not synchronized.
- Latency: with SYNC_STAGES=2, an input change before edge N is seen by the FSM at edge N+2 and by the outputs at that edge. All outputs are registered and update on the same edge as state.
- States: IDLE=00, COOK=01, PAUSE=10, DONE=11.
- IDLE transitions:
  - start press & door_closed & !timer_done → COOK.
  - clear press → IDLE, with a timer_clear pulse.
  - All else stays in IDLE.
- COOK transitions, priority clear > timer_done > door open > stop:
  - clear press → IDLE + timer_clear pulse.
  - timer_done → DONE.
  - !door_closed → PAUSE.
  - stop press → PAUSE.
  - start press ignored.
- PAUSE transitions, priority clear/stop > start:
  - clear press or stop press → IDLE + timer_clear pulse.
  - start press & door_closed & !timer_done → COOK.
  - Opening/closing the door alone never resumes cooking.
- DONE transitions:
  - On entry, beep counter loads BEEP_CYCLES-1.
  - Counter decrements each cycle; at 0 → IDLE.
  - Any press (start/stop/clear) or door opening → IDLE immediately, beep drops on that edge.
  - No timer_clear is issued (timer already zero).
- Output decode (Moore, registered):
  - magnetron_on=1 and timer_en=1 only in COOK.
  - beep=1 only in DONE. Exactly BEEP_CYCLES cycles if uninterrupted.
  - lamp_on = (state==COOK) | !door_closed_sync.
  - timer_clear=1 for the single cycle after any transition that specifies it, otherwise 0.
- Safety invariants (assert in bench):
  - magnetron_on never 1 while the synchronized door_closed is 0 for more than the one FSM reaction cycle.
  - magnetron_on never 1 outside COOK.
- Simultaneous presses in the same cycle resolve by the priority lists above.
- Reset mid-COOK: outputs drop asynchronously, no timer_clear issued. The countdown keeps its value; the timer's own reset owns that.

Test Plan:
- Door closed, timer_done=0, pulse startn low 3 cycles → state=01 and magnetron_on=timer_en=lamp_on=1 two edges after sync. Holding startn low further creates no extra events.
- In COOK, drop door_closed → PAUSE, magnetron_on=0, lamp_on=1. Close door → stays PAUSE. Press start → COOK.
- In COOK, assert timer_done=1 → DONE. With BEEP_CYCLES=4, beep high exactly 4 cycles, then state=00 and beep=0.
- In COOK, press stop → PAUSE. Press stop again → IDLE with timer_clear high exactly 1 cycle. In IDLE, start with timer_done=1 → stays IDLE.
- Same-cycle clearn and timer_done falling/asserted in COOK → IDLE with timer_clear pulse, not DONE. Same-cycle start+stop in PAUSE → IDLE.
- Assert rstn low mid-COOK and mid-DONE → all outputs 0 immediately, without waiting for clk. Release → IDLE. Then 3000 cycles of random buttons/door/timer_done, checking the safety invariants throughout.
